ps2_keyboard_rx: RTL and testbench

Host-side PS/2 receiver. It samples the keyboard's ps2_clk/ps2_data lines, deframes 11-bit device-to-host frames and checks them, then decodes make/break scancodes into three held key levels: left, right and fire. These levels replace the raw board buttons that feed the delay stage ahead of position_rect_ctl and missle_ctl. The block never drives the bus; the top level ties the inout pads to its inputs and leaves the pads undriven (high-Z).

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_rx_frame.sv | 152 +++++++++++++++
 rtl/ps2_keyboard_rx.sv | 71 +++++++
 tb/tb_ps2_keyboard_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver: scancodes, frame FSM
// encoding, default timing parameters and the frame parity helper.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int DEF_FILTER_LEN  = 8;
    localparam int DEF_TIMEOUT_CYC = 131072;
    localparam int DEF_TO_W        = 18;

    // A PS/2 frame carries odd parity across the eight data bits plus parity.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 line conditioning and 11-bit frame deframer: synchronizes and filters
// both pads, shifts bits on filtered clock falls and validates each frame.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int TO_W        = DEF_TO_W
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int FC_W = $clog2(FILTER_LEN + 1);

    logic            clk_p0, clk_p1, dat_p0, dat_p1;
    logic [FC_W-1:0] clk_cnt, dat_cnt;
    logic            clk_f, clk_f_d, dat_f;
    logic            fall;
    logic [1:0]      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      sh;
    logic            par;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    // stage p0/p1: two-flop synchronizers, idle-high after reset
    always_ff @(posedge pclk) begin
        if (rst) begin
            clk_p0 <= 1'b1;
            clk_p1 <= 1'b1;
            dat_p0 <= 1'b1;
            dat_p1 <= 1'b1;
        end else begin
            clk_p0 <= ps2_clk_in;
            clk_p1 <= clk_p0;
            dat_p0 <= ps2_data_in;
            dat_p1 <= dat_p0;
        end
    end

    // stage filter: output follows only after FILTER_LEN consecutive differing samples
    always_ff @(posedge pclk) begin
        if (rst) begin
            clk_cnt <= '0;
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
        end else begin
            clk_f_d <= clk_f;
            if (clk_p1 == clk_f) begin
                clk_cnt <= '0;
            end else if (clk_cnt == FC_W'(FILTER_LEN - 1)) begin
                clk_f   <= clk_p1;
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + FC_W'(1);
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            dat_cnt <= '0;
            dat_f   <= 1'b1;
        end else begin
            if (dat_p1 == dat_f) begin
                dat_cnt <= '0;
            end else if (dat_cnt == FC_W'(FILTER_LEN - 1)) begin
                dat_f   <= dat_p1;
                dat_cnt <= '0;
            end else begin
                dat_cnt <= dat_cnt + FC_W'(1);
            end
        end
    end

    assign fall = clk_f_d & ~clk_f;

    // A fall coinciding with expiry wins, so a slow but legal edge is never lost.
    assign to_hit = (state != ST_IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // stage frame: FSM, timeout and result pulses
    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            scan_code  <= 8'h00;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall || state == ST_IDLE) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (to_hit) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!dat_f) begin
                            bit_cnt <= '0;
                            state   <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (dat_f && odd_parity_ok(sh, par)) begin
                            scan_valid <= 1'b1;
                            scan_code  <= sh;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Data shift path carries no reset; the FSM decides when its contents matter.
    always_ff @(posedge pclk) begin
        if (fall && !to_hit) begin
            if (state == ST_SHIFT) begin
                sh <= {dat_f, sh[7:1]};
            end
            if (state == ST_PARITY) begin
                par <= dat_f;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver top: frame deframer plus make/break decoder that
// holds left, right and fire levels for the game controls.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int TO_W        = DEF_TO_W
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err,
    output logic       left,
    output logic       right,
    output logic       fire
);

    logic ext;
    logic brk;

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_frame (
        .pclk        (pclk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .frame_err   (frame_err)
    );

    // stage decode: prefix flags are order-independent and cleared by any final code or error
    always_ff @(posedge pclk) begin
        if (rst) begin
            ext   <= 1'b0;
            brk   <= 1'b0;
            left  <= 1'b0;
            right <= 1'b0;
            fire  <= 1'b0;
        end else if (frame_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (scan_valid) begin
            case (scan_code)
                SC_BRK: brk <= 1'b1;
                SC_EXT: ext <= 1'b1;
                default: begin
                    if (ext && scan_code == SC_LEFT) begin
                        left <= ~brk;
                    end
                    if (ext && scan_code == SC_RIGHT) begin
                        right <= ~brk;
                    end
                    if (!ext && scan_code == SC_SPACE) begin
                        fire <= ~brk;
                    end
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: table of frames with expected key levels,
// plus sequences for reset, latency, timeout, glitch rejection and mid-frame reset.
module tb_ps2_keyboard_rx;

    localparam int FL   = 8;
    localparam int TO   = 512;
    localparam int TOW  = 10;
    localparam int HALF = 20;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err, left, right, fire;

    ps2_keyboard_rx #(
        .FILTER_LEN  (FL),
        .TIMEOUT_CYC (TO),
        .TO_W        (TOW)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk),
        .ps2_data_in (ps2_dat),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .frame_err   (frame_err),
        .left        (left),
        .right       (right),
        .fire        (fire)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    int valid_cnt = 0, err_cnt = 0, valid_cyc = 0, err_cyc = 0, fall_cyc = 0;
    int n_vec = 0, n_bad = 0;

    always @(posedge pclk) cyc++;

    always @(negedge pclk) begin
        if (scan_valid === 1'b1) begin
            valid_cnt++;
            valid_cyc = cyc;
        end
        if (frame_err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    typedef struct {
        string      name;
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_code;
        bit         exp_left;
        bit         exp_right;
        bit         exp_fire;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string n, logic [7:0] d, bit bp, bit bs, int ev, int ee,
                                logic [7:0] ec, bit l, bit r, bit f);
        vec_t v;
        v.name = n; v.data = d; v.bad_par = bp; v.bad_stop = bs;
        v.exp_valid = ev; v.exp_err = ee; v.exp_code = ec;
        v.exp_left = l; v.exp_right = r; v.exp_fire = f;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic send_bit(logic b);
        ps2_dat = b;
        idle(HALF);
        ps2_clk = 1'b0;
        fall_cyc = cyc;
        idle(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(logic [7:0] d, logic bad_par, logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(~bad_stop);
        ps2_dat = 1'b1;
        idle(3 * HALF);
    endtask

    task automatic frame_check(string nm, logic [7:0] d, int ev, logic [7:0] ec);
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(d, 1'b0, 1'b0);
        check({nm, "_valid"}, valid_cnt - v0, ev);
        check({nm, "_err"}, err_cnt - e0, 0);
        check({nm, "_code"}, 32'(ec), 32'(scan_code));
    endtask

    initial begin
        int v0, e0;

        tbl.push_back(mk("fire_make",    8'h29, 0, 0, 1, 0, 8'h29, 0, 0, 1));
        tbl.push_back(mk("fire_brkpfx",  8'hF0, 0, 0, 1, 0, 8'hF0, 0, 0, 1));
        tbl.push_back(mk("fire_break",   8'h29, 0, 0, 1, 0, 8'h29, 0, 0, 0));
        tbl.push_back(mk("left_ext",     8'hE0, 0, 0, 1, 0, 8'hE0, 0, 0, 0));
        tbl.push_back(mk("left_make",    8'h6B, 0, 0, 1, 0, 8'h6B, 1, 0, 0));
        tbl.push_back(mk("right_ext",    8'hE0, 0, 0, 1, 0, 8'hE0, 1, 0, 0));
        tbl.push_back(mk("right_make",   8'h74, 0, 0, 1, 0, 8'h74, 1, 1, 0));
        tbl.push_back(mk("lrel_ext",     8'hE0, 0, 0, 1, 0, 8'hE0, 1, 1, 0));
        tbl.push_back(mk("lrel_brk",     8'hF0, 0, 0, 1, 0, 8'hF0, 1, 1, 0));
        tbl.push_back(mk("lrel_code",    8'h6B, 0, 0, 1, 0, 8'h6B, 0, 1, 0));
        tbl.push_back(mk("bad_parity",   8'h74, 1, 0, 0, 1, 8'h6B, 0, 1, 0));
        tbl.push_back(mk("bad_stop",     8'h74, 0, 1, 0, 1, 8'h6B, 0, 1, 0));
        tbl.push_back(mk("rrel_brk",     8'hF0, 0, 0, 1, 0, 8'hF0, 0, 1, 0));
        tbl.push_back(mk("rrel_ext",     8'hE0, 0, 0, 1, 0, 8'hE0, 0, 1, 0));
        tbl.push_back(mk("rrel_code",    8'h74, 0, 0, 1, 0, 8'h74, 0, 0, 0));
        tbl.push_back(mk("fire_again",   8'h29, 0, 0, 1, 0, 8'h29, 0, 0, 1));
        tbl.push_back(mk("fire_typem",   8'h29, 0, 0, 1, 0, 8'h29, 0, 0, 1));
        tbl.push_back(mk("both_ext",     8'hE0, 0, 0, 1, 0, 8'hE0, 0, 0, 1));
        tbl.push_back(mk("both_left",    8'h6B, 0, 0, 1, 0, 8'h6B, 1, 0, 1));
        tbl.push_back(mk("unmatched_aa", 8'hAA, 0, 0, 1, 0, 8'hAA, 1, 0, 1));
        tbl.push_back(mk("err_ext",      8'hE0, 0, 0, 1, 0, 8'hE0, 1, 0, 1));
        tbl.push_back(mk("err_drop",     8'h74, 1, 0, 0, 1, 8'hE0, 1, 0, 1));
        tbl.push_back(mk("err_noext74",  8'h74, 0, 0, 1, 0, 8'h74, 1, 0, 1));
        tbl.push_back(mk("plain_brk",    8'hF0, 0, 0, 1, 0, 8'hF0, 1, 0, 1));
        tbl.push_back(mk("plain_6b",     8'h6B, 0, 0, 1, 0, 8'h6B, 1, 0, 1));

        // Reset and idle bus
        idle(4);
        check("rst_code", 32'(scan_code), 32'h0);
        check("rst_keys", 32'({left, right, fire}), 32'h0);
        rst = 1'b0;
        idle(200);
        check("idle_valid", valid_cnt, 0);
        check("idle_err", err_cnt, 0);
        check("idle_code", 32'(scan_code), 32'h0);
        check("idle_keys", 32'({left, right, fire}), 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t t;
            t = tbl[i];
            v0 = valid_cnt;
            e0 = err_cnt;
            send_frame(t.data, t.bad_par, t.bad_stop);
            check({t.name, "_valid"}, valid_cnt - v0, t.exp_valid);
            check({t.name, "_err"}, err_cnt - e0, t.exp_err);
            check({t.name, "_code"}, 32'(scan_code), 32'(t.exp_code));
            check({t.name, "_left"}, 32'(left), 32'(t.exp_left));
            check({t.name, "_right"}, 32'(right), 32'(t.exp_right));
            check({t.name, "_fire"}, 32'(fire), 32'(t.exp_fire));
            if (t.exp_valid == 1)
                check({t.name, "_latency_ok"}, 32'(valid_cyc - fall_cyc <= FL + 4), 32'h1);
        end

        // Timeout: E0 sets ext, then a 4-bit partial frame must abort and clear it
        frame_check("to_pre_e0", 8'hE0, 1, 8'hE0);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        ps2_dat = 1'b1;
        for (int k = 0; k < TO + 200 && err_cnt == e0; k++) @(negedge pclk);
        idle(4);
        check("to_err", err_cnt - e0, 1);
        // filtered fall is consumed FL+3 cycles after the pad edge, expiry TO cycles later
        check("to_time", err_cyc - fall_cyc, TO + FL + 3);
        check("to_valid", valid_cnt - v0, 0);
        check("to_code", 32'(scan_code), 32'hE0);
        frame_check("to_post74", 8'h74, 1, 8'h74);
        check("to_right", 32'(right), 32'h0);
        frame_check("to_post29", 8'h29, 1, 8'h29);
        check("to_fire", 32'(fire), 32'h1);

        // Short low glitch on the clock with data low must not start a frame
        v0 = valid_cnt;
        e0 = err_cnt;
        ps2_dat = 1'b0;
        idle(HALF);
        ps2_clk = 1'b0;
        idle(FL - 2);
        ps2_clk = 1'b1;
        idle(HALF);
        ps2_dat = 1'b1;
        idle(HALF);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_err", err_cnt - e0, 0);
        frame_check("glitch_f0", 8'hF0, 1, 8'hF0);
        frame_check("glitch_e0", 8'hE0, 1, 8'hE0);
        frame_check("glitch_6b", 8'h6B, 1, 8'h6B);
        check("glitch_left", 32'(left), 32'h0);

        // Reset mid-frame clears everything; the next frame decodes normally
        frame_check("mrst_e0", 8'hE0, 1, 8'hE0);
        frame_check("mrst_74", 8'h74, 1, 8'h74);
        check("mrst_right_pre", 32'(right), 32'h1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        idle(3);
        rst = 1'b0;
        v0 = valid_cnt;
        e0 = err_cnt;
        idle(50);
        check("mrst_code", 32'(scan_code), 32'h0);
        check("mrst_keys", 32'({left, right, fire}), 32'h0);
        check("mrst_valid", valid_cnt - v0, 0);
        check("mrst_err", err_cnt - e0, 0);
        frame_check("post_e0", 8'hE0, 1, 8'hE0);
        frame_check("post_74", 8'h74, 1, 8'h74);
        check("post_keys", 32'({left, right, fire}), 32'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
